// File: rtl/subpel_pkg.sv
// rtl/subpel_pkg.sv - shared constants, coefficient table and clip helper for subpel_interp_2d
package subpel_pkg;

  // Fraction coding carried on frac_x / frac_y.
  typedef enum logic [1:0] {
    FRAC_INT  = 2'd0,
    FRAC_QTR  = 2'd1,
    FRAC_HALF = 2'd2,
    FRAC_3QTR = 2'd3
  } frac_e;

  // Block-level control states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  localparam int PIX_W  = 8;
  localparam int COEF_W = 8;
  localparam int TAPS   = 8;
  localparam int MID_W  = 16;  // horizontal-pass intermediate
  localparam int ACC_W  = 24;  // vertical-pass accumulator

  localparam logic signed [ACC_W-1:0] ROUND_ADD = 24'sd32;
  localparam logic signed [ACC_W-1:0] PIX_MAX   = 24'sd255;

  // Luma filter taps 0..7, one row per fraction.
  localparam logic signed [COEF_W-1:0] COEF_TAB [4][TAPS] = '{
    '{ 8'sd0,  8'sd0,   8'sd0,  8'sd64,  8'sd0,   8'sd0,  8'sd0,  8'sd0 },
    '{-8'sd1,  8'sd4, -8'sd10,  8'sd58,  8'sd17, -8'sd5,  8'sd1,  8'sd0 },
    '{-8'sd1,  8'sd4, -8'sd11,  8'sd40,  8'sd40, -8'sd11, 8'sd4, -8'sd1 },
    '{ 8'sd0,  8'sd1,  -8'sd5,  8'sd17,  8'sd58, -8'sd10, 8'sd4, -8'sd1 }
  };

  // Packs one coefficient set with tap 0 in the least significant byte.
  function automatic logic [TAPS*COEF_W-1:0] coef_vec(input logic [1:0] frac);
    logic [TAPS*COEF_W-1:0] v;
    v = '0;
    for (int k = 0; k < TAPS; k++) begin
      v[k*COEF_W +: COEF_W] = COEF_TAB[frac][k];
    end
    return v;
  endfunction

  // Two-stage normalisation: the first shift undoes the horizontal gain of 64
  // without rounding, the second rounds away the vertical gain.
  function automatic logic [PIX_W-1:0] clip_pix(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] t;
    t = (v >>> 6) + ROUND_ADD;
    t = t >>> 6;
    if (t[ACC_W-1]) begin
      return '0;
    end else if (t > PIX_MAX) begin
      return 8'hFF;
    end else begin
      return t[PIX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/subpel_fir8.sv
// rtl/subpel_fir8.sv - combinational 8-tap signed dot product
//
// Ports:
//   x     8 signed samples of IN_W bits, tap 0 in the low slice
//   coef  8 signed COEF_W-bit coefficients, tap 0 in the low byte
//   y     signed OUT_W-bit sum of products
module subpel_fir8
  import subpel_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 24
) (
  input  logic [TAPS*IN_W-1:0]   x,
  input  logic [TAPS*COEF_W-1:0] coef,
  output logic signed [OUT_W-1:0] y
);

  logic signed [OUT_W-1:0] acc;
  logic signed [OUT_W-1:0] xe;
  logic signed [OUT_W-1:0] ce;

  // Both operands are sign-extended to the output width before the multiply,
  // so each product and the running sum stay exact.
  always_comb begin
    acc = '0;
    xe  = '0;
    ce  = '0;
    for (int k = 0; k < TAPS; k++) begin
      xe  = OUT_W'($signed(x[k*IN_W +: IN_W]));
      ce  = OUT_W'($signed(coef[k*COEF_W +: COEF_W]));
      acc = acc + xe * ce;
    end
    y = acc;
  end

endmodule

// File: rtl/subpel_interp_2d.sv
// rtl/subpel_interp_2d.sv - separable 2-D 8-tap luma sub-pel interpolator with row flow control
//
// Ports:
//   clk, rst         clock; asynchronous active-low reset
//   start            one-cycle block start, honoured only when idle
//   frac_x, frac_y   fractions latched on an accepted start
//   busy, done       block in progress; one-cycle completion pulse
//   in_valid/ready   reference row handshake, in_row holds BLK_W+7 pixels
//   out_valid/ready  output row handshake, out_row holds BLK_W pixels
//   out_row_idx      row number of out_row within the block
module subpel_interp_2d
  import subpel_pkg::*;
#(
  parameter int BLK_W = 8,
  parameter int BLK_H = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [1:0]                   frac_x,
  input  logic [1:0]                   frac_y,
  output logic                         busy,
  output logic                         done,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [(BLK_W+7)*PIX_W-1:0]   in_row,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BLK_W*PIX_W-1:0]       out_row,
  output logic [$clog2(BLK_H)-1:0]     out_row_idx
);

  localparam int IDX_W  = $clog2(BLK_H);
  localparam int CNT_W  = $clog2(BLK_H + 8);
  localparam int H_IN_W = PIX_W + 1;  // pixels enter the FIR zero-extended
  localparam int HIST   = TAPS - 1;   // stored rows; the eighth is the row being accepted

  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(HIST - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(BLK_H + HIST - 1);

  state_e state_q;
  state_e state_d;

  logic [1:0]             fx_q;
  logic [1:0]             fy_q;
  logic [CNT_W-1:0]       in_cnt;
  logic [IDX_W-1:0]       out_cnt;
  logic                   accept;
  logic                   done_d;

  logic [TAPS*COEF_W-1:0] cx;
  logic [TAPS*COEF_W-1:0] cy;

  // hist[0] is the oldest intermediate row, hist[HIST-1] the newest.
  logic [BLK_W*MID_W-1:0] hist [HIST];
  logic [BLK_W*MID_W-1:0] h_row;
  logic [BLK_W*PIX_W-1:0] o_row;

  assign cx = coef_vec(fx_q);
  assign cy = coef_vec(fy_q);

  // ---------------------------------------------------------------------
  // Datapath: per column, horizontal FIR on the incoming row, then vertical
  // FIR over the window as it will look after this row is shifted in. That
  // lets the output register load in the same edge as the accept.
  // ---------------------------------------------------------------------
  for (genvar j = 0; j < BLK_W; j++) begin : g_col
    logic [TAPS*H_IN_W-1:0]  hx;
    logic [TAPS*MID_W-1:0]   vx;
    logic signed [MID_W-1:0] h_j;
    logic signed [ACC_W-1:0] v_j;

    for (genvar k = 0; k < TAPS; k++) begin : g_hx
      assign hx[k*H_IN_W +: H_IN_W] = {1'b0, in_row[(j+k)*PIX_W +: PIX_W]};
    end

    subpel_fir8 #(
      .IN_W (H_IN_W),
      .OUT_W(MID_W)
    ) u_fir_h (
      .x   (hx),
      .coef(cx),
      .y   (h_j)
    );

    assign h_row[j*MID_W +: MID_W] = h_j;

    for (genvar k = 0; k < HIST; k++) begin : g_vx
      assign vx[k*MID_W +: MID_W] = hist[k][j*MID_W +: MID_W];
    end
    assign vx[HIST*MID_W +: MID_W] = h_j;

    subpel_fir8 #(
      .IN_W (MID_W),
      .OUT_W(ACC_W)
    ) u_fir_v (
      .x   (vx),
      .coef(cy),
      .y   (v_j)
    );

    assign o_row[j*PIX_W +: PIX_W] = clip_pix(v_j);
  end

  // ---------------------------------------------------------------------
  // Block FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid && (in_cnt == FILL_LAST)) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // A row may enter only if the output slot is empty or is being
        // drained this same cycle.
        in_ready = !out_valid || out_ready;
        if (in_valid && in_ready && (in_cnt == RUN_LAST)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_valid && out_ready) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign accept = in_valid && in_ready;
  assign busy   = (state_q != S_IDLE);

  // ---------------------------------------------------------------------
  // Window, counters and output register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fx_q        <= '0;
      fy_q        <= '0;
      in_cnt      <= '0;
      out_cnt     <= '0;
      out_valid   <= 1'b0;
      out_row     <= '0;
      out_row_idx <= '0;
      done        <= 1'b0;
      for (int k = 0; k < HIST; k++) begin
        hist[k] <= '0;
      end
    end else begin
      done <= done_d;

      if ((state_q == S_IDLE) && start) begin
        fx_q    <= frac_x;
        fy_q    <= frac_y;
        in_cnt  <= '0;
        out_cnt <= '0;
      end

      if (accept) begin
        for (int k = 0; k < HIST - 1; k++) begin
          hist[k] <= hist[k+1];
        end
        hist[HIST-1] <= h_row;
        in_cnt       <= in_cnt + CNT_W'(1);
      end

      if (accept && (state_q == S_RUN)) begin
        out_valid   <= 1'b1;
        out_row     <= o_row;
        out_row_idx <= out_cnt;
        out_cnt     <= out_cnt + IDX_W'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_subpel_interp_2d.sv
// tb/tb_subpel_interp_2d.sv - self-checking bench for subpel_interp_2d
module tb_subpel_interp_2d;

  localparam int BLK_W    = 8;
  localparam int BLK_H    = 8;
  localparam int NROWS    = BLK_H + 7;
  localparam int IN_PIX   = BLK_W + 7;
  localparam int IN_BITS  = IN_PIX * 8;
  localparam int OUT_BITS = BLK_W * 8;
  localparam int IDX_W    = $clog2(BLK_H);
  localparam int LIMIT    = 600;

  localparam int CF [4][8] = '{
    '{ 0, 0,   0, 64,  0,   0, 0,  0},
    '{-1, 4, -10, 58, 17,  -5, 1,  0},
    '{-1, 4, -11, 40, 40, -11, 4, -1},
    '{ 0, 1,  -5, 17, 58, -10, 4, -1}
  };

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic [1:0]          frac_x = 2'd0;
  logic [1:0]          frac_y = 2'd0;
  logic                busy;
  logic                done;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [IN_BITS-1:0]  in_row = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [OUT_BITS-1:0] out_row;
  logic [IDX_W-1:0]    out_row_idx;

  int checks   = 0;
  int failures = 0;

  logic [IN_BITS-1:0]  rows     [NROWS];
  logic [OUT_BITS-1:0] exp_rows [BLK_H];
  logic [OUT_BITS-1:0] exp_q [$];
  logic [IDX_W-1:0]    idx_q [$];

  subpel_interp_2d #(
    .BLK_W(BLK_W),
    .BLK_H(BLK_H)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .frac_x     (frac_x),
    .frac_y     (frac_y),
    .busy       (busy),
    .done       (done),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_row     (in_row),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_row    (out_row),
    .out_row_idx(out_row_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [OUT_BITS-1:0] model_row(input int i, input logic [1:0] fx,
                                                    input logic [1:0] fy);
    logic [OUT_BITS-1:0] r;
    int h, v, t;
    r = '0;
    for (int j = 0; j < BLK_W; j++) begin
      v = 0;
      for (int ky = 0; ky < 8; ky++) begin
        h = 0;
        for (int kx = 0; kx < 8; kx++) begin
          h += CF[fx][kx] * int'(rows[i+ky][(j+kx)*8 +: 8]);
        end
        v += CF[fy][ky] * h;
      end
      t = ((v >>> 6) + 32) >>> 6;
      if (t < 0) t = 0;
      else if (t > 255) t = 255;
      r[j*8 +: 8] = t[7:0];
    end
    return r;
  endfunction

  task automatic fill_random_rows();
    for (int r = 0; r < NROWS; r++) begin
      for (int p = 0; p < IN_PIX; p++) begin
        rows[r][p*8 +: 8] = 8'($urandom_range(0, 255));
      end
    end
  endtask

  task automatic fill_model(input logic [1:0] fx, input logic [1:0] fy);
    for (int i = 0; i < BLK_H; i++) exp_rows[i] = model_row(i, fx, fy);
  endtask

  // Runs one full block. mode 0: always valid/ready; 1: five-cycle output
  // stall after the third output; 2: random valid/ready. poke re-pulses start
  // mid-block with different fractions.
  task automatic run_block(input logic [1:0] fx, input logic [1:0] fy, input int mode,
                           input logic [BLK_W-1:0] mask, input bit poke);
    int acc_n, hs_n, cyc, hold;
    bit early_done, lat_seen, bad;
    logic [OUT_BITS-1:0] held_row, e_row;
    logic [IDX_W-1:0] held_idx, e_idx;
    exp_q.delete();
    idx_q.delete();
    acc_n = 0; hs_n = 0; cyc = 0; hold = 0;
    early_done = 0; lat_seen = 0;
    held_row = '0; held_idx = '0;
    @(negedge clk);
    start = 1'b1; frac_x = fx; frac_y = fy;
    @(negedge clk);
    start = 1'b0; frac_x = ~fx; frac_y = ~fy;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_rise got=%b exp=1", busy);
    end
    while (hs_n < BLK_H && cyc < LIMIT) begin
      in_valid  = (acc_n < NROWS) && (mode != 2 || $urandom_range(0, 3) != 0);
      in_row    = in_valid ? rows[acc_n] : IN_BITS'({$urandom, $urandom, $urandom, $urandom});
      out_ready = (hold > 0) ? 1'b0 : ((mode != 2) || ($urandom_range(0, 2) != 0));
      start     = poke && (acc_n == 3);
      #1;
      if (done) early_done = 1;
      if (mode == 0 && acc_n == 8 && !lat_seen) begin
        lat_seen = 1;
        checks++;
        if (out_valid !== 1'b1 || out_row_idx !== '0) begin
          failures++;
          $display("FAIL latency out_valid=%b idx=%0d exp valid=1 idx=0", out_valid, out_row_idx);
        end
      end
      if (hold > 0) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          failures++;
          $display("FAIL stall_ready in_ready=%b out_valid=%b exp 0/1", in_ready, out_valid);
        end
        if (hold == 5) begin
          held_row = out_row;
          held_idx = out_row_idx;
        end else begin
          checks++;
          if (out_row !== held_row || out_row_idx !== held_idx) begin
            failures++;
            $display("FAIL stall_hold got=%h/%0d exp=%h/%0d", out_row, out_row_idx, held_row, held_idx);
          end
        end
        hold--;
      end
      if (in_valid && in_ready) begin
        if (acc_n >= 7) begin
          exp_q.push_back(exp_rows[acc_n-7]);
          idx_q.push_back(IDX_W'(acc_n - 7));
        end
        acc_n++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_row got_idx=%0d exp=none", out_row_idx);
        end else begin
          e_row = exp_q.pop_front();
          e_idx = idx_q.pop_front();
          bad = 0;
          for (int j = 0; j < BLK_W; j++) begin
            if (mask[j] && out_row[j*8 +: 8] !== e_row[j*8 +: 8]) bad = 1;
          end
          if (bad) begin
            failures++;
            $display("FAIL row_data idx=%0d got=%h exp=%h mask=%b", e_idx, out_row, e_row, mask);
          end
          checks++;
          if (out_row_idx !== e_idx) begin
            failures++;
            $display("FAIL row_idx got=%0d exp=%0d", out_row_idx, e_idx);
          end
        end
        hs_n++;
        if (mode == 1 && hs_n == 3) hold = 5;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (cyc >= LIMIT || acc_n != NROWS || exp_q.size() != 0) begin
      failures++;
      $display("FAIL block_complete rows_in=%0d rows_out=%0d exp=%0d/%0d", acc_n, hs_n, NROWS, BLK_H);
    end
    checks++;
    if (early_done) begin
      failures++;
      $display("FAIL early_done got=1 exp=0");
    end
    #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse done=%b busy=%b out_valid=%b exp 1/0/0", done, busy, out_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_width got=%b exp=0", done);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl in_ready=%b out_valid=%b busy=%b done=%b exp all 0",
               in_ready, out_valid, busy, done);
    end
    checks++;
    if (out_row !== '0 || out_row_idx !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h/%0d exp=0/0", out_row, out_row_idx);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_ready in_ready=%b busy=%b exp 0/0", in_ready, busy);
    end
  endtask

  task automatic test_pass_through();
    logic [7:0] pv;
    for (int r = 0; r < NROWS; r++) begin
      pv = 8'((r * 7) & 255);
      rows[r] = {IN_PIX{pv}};
    end
    for (int i = 0; i < BLK_H; i++) begin
      pv = 8'(((i + 3) * 7) & 255);
      exp_rows[i] = {BLK_W{pv}};
    end
    run_block(2'd0, 2'd0, 0, '1, 1'b0);
  endtask

  task automatic test_flat();
    logic [7:0] pv;
    pv = 8'd100;
    for (int r = 0; r < NROWS; r++) rows[r] = {IN_PIX{pv}};
    for (int i = 0; i < BLK_H; i++) exp_rows[i] = {BLK_W{pv}};
    for (int fx = 0; fx < 4; fx++) begin
      for (int fy = 0; fy < 4; fy++) begin
        run_block(2'(fx), 2'(fy), 0, '1, 1'b0);
      end
    end
  endtask

  task automatic run_col0(input int hi_mask, input logic [7:0] exp_pix);
    for (int r = 0; r < NROWS; r++) begin
      for (int p = 0; p < IN_PIX; p++) begin
        rows[r][p*8 +: 8] = (p < 8 && hi_mask[p]) ? 8'd255 : 8'd0;
      end
    end
    for (int i = 0; i < BLK_H; i++) begin
      exp_rows[i] = '0;
      exp_rows[i][7:0] = exp_pix;
    end
    run_block(2'd2, 2'd0, 0, BLK_W'(1), 1'b0);
  endtask

  task automatic test_edge();
    run_col0(32'hF0, 8'd128);
  endtask

  task automatic test_clip();
    run_col0(32'h18, 8'd255);
    run_col0(32'hE7, 8'd0);
  endtask

  task automatic test_backpressure();
    fill_random_rows();
    fill_model(2'd1, 2'd3);
    run_block(2'd1, 2'd3, 1, '1, 1'b0);
  endtask

  task automatic test_start_ignored();
    fill_random_rows();
    fill_model(2'd2, 2'd1);
    run_block(2'd2, 2'd1, 0, '1, 1'b1);
  endtask

  task automatic test_random_flow();
    fill_random_rows();
    fill_model(2'd3, 2'd2);
    run_block(2'd3, 2'd2, 2, '1, 1'b0);
  endtask

  task automatic test_reset_abort();
    int acc_n, cyc;
    bit saw_done;
    acc_n = 0; cyc = 0; saw_done = 0;
    fill_random_rows();
    @(negedge clk);
    start = 1'b1; frac_x = 2'd1; frac_y = 2'd2;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    while (acc_n < 10 && cyc < 100) begin
      in_row = rows[acc_n];
      #1;
      if (in_ready) acc_n++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (acc_n != 10 || out_valid !== 1'b1 || out_row_idx !== IDX_W'(2)) begin
      failures++;
      $display("FAIL pre_abort accepts=%0d out_valid=%b idx=%0d exp 10/1/2", acc_n, out_valid, out_row_idx);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0
        || out_row !== '0 || out_row_idx !== '0) begin
      failures++;
      $display("FAIL abort_reset in_ready=%b out_valid=%b busy=%b done=%b row=%h idx=%0d exp all 0",
               in_ready, out_valid, busy, done, out_row, out_row_idx);
    end
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    checks++;
    if (saw_done || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_done saw_done=%b busy=%b exp 0/0", saw_done, busy);
    end
    fill_random_rows();
    fill_model(2'd1, 2'd2);
    run_block(2'd1, 2'd2, 0, '1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_flat();
    test_edge();
    test_clip();
    test_backpressure();
    test_start_ignored();
    test_random_flow();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
